// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALU operations,
// controller states and the datapath mux select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_LD    = 4'd1,
        OP_ST    = 4'd2,
        OP_ADDI  = 4'd3,
        OP_BEQ   = 4'd4,
        OP_BNE   = 4'd5,
        OP_J     = 4'd6,
        OP_HALT  = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDI_EX = 4'd8,
        S_ADDI_WB = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REG    = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    // States that stall on the memory handshake and are covered by the watchdog.
    function automatic logic isWaitState(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// Combinational selection of the ALU operation from the controller state,
// the IR opcode and the R-type funct field.
module multicycle_ctrl_alu_op_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [2:0]          funct_i,
    output logic [ALUOP_W-1:0]  aluOp_o
);

    // Address/PC arithmetic is ADD everywhere; only R-type execute and branch compare differ.
    always_comb begin
        aluOp_o = ALUOP_W'(ALU_ADD);
        case (state_i)
            S_EXEC: begin
                if (opcode_i == OPCODE_W'(OP_RTYPE)) begin
                    aluOp_o = ALUOP_W'(funct_i);
                end
            end
            S_BRANCH: aluOp_o = ALUOP_W'(ALU_SUB);
            default:  aluOp_o = ALUOP_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle processor: sequences the shared ALU and
// memory, with a memory wait-state watchdog and HALT/illegal-opcode handling.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int OPCODE_W   = 4,
    parameter int ALUOP_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [2:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [ALUOP_W-1:0]  ALU_Op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic                halted,
    output logic [3:0]          state_dbg
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                timeout_q, timeout_d;

    logic isRtype, isLd, isSt, isAddi, isBeq, isBne, isJump, isHalt;
    logic waiting, limitHit;
    logic pcEn, memRead, memWrite, irWrite, regWrite;

    assign isRtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign isLd    = (opcode == OPCODE_W'(OP_LD));
    assign isSt    = (opcode == OPCODE_W'(OP_ST));
    assign isAddi  = (opcode == OPCODE_W'(OP_ADDI));
    assign isBeq   = (opcode == OPCODE_W'(OP_BEQ));
    assign isBne   = (opcode == OPCODE_W'(OP_BNE));
    assign isJump  = (opcode == OPCODE_W'(OP_J));
    assign isHalt  = (opcode == OPCODE_W'(OP_HALT));

    // A stalled cycle that would bring the count up to the limit trips the watchdog;
    // mem_ready in that same cycle means the state is not stalled, so it wins.
    assign waiting  = isWaitState(state_q) && !mem_ready;
    assign limitHit = waiting && (waitCnt_q == WCNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            waitCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        waitCnt_d = '0;
        timeout_d = timeout_q;
        if (limitHit) begin
            timeout_d = 1'b1;
        end else if (waiting) begin
            waitCnt_d = waitCnt_q + WCNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        pc_src     = PC_ALU;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pcEn       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = mem_ready;
                pcEn    = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (limitHit) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                if (isLd || isSt) begin
                    state_d = S_MEMADR;
                end else if (isRtype) begin
                    state_d = S_EXEC;
                end else if (isAddi) begin
                    state_d = S_ADDI_EX;
                end else if (isBeq || isBne) begin
                    state_d = S_BRANCH;
                end else if (isJump) begin
                    state_d = S_JUMP;
                end else if (isHalt) begin
                    state_d = S_HALT;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                if (isLd) begin
                    state_d = S_MEMRD;
                end else if (isSt) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                memRead = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (limitHit) begin
                    state_d = S_HALT;
                end
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (limitHit) begin
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                reg_dst  = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                pc_src    = PC_ALUOUT;
                pcEn      = isBeq ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PC_JUMP;
                pcEn    = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // While reset is held the state already reads FETCH, but its Mealy enables must stay off.
    assign pc_en     = pcEn & rst_n;
    assign mem_read  = memRead & rst_n;
    assign mem_write = memWrite & rst_n;
    assign ir_write  = irWrite & rst_n;
    assign reg_write = regWrite & rst_n;

    assign mem_timeout = timeout_q;
    assign halted      = (state_q == S_HALT);
    assign state_dbg   = state_q;

    multicycle_ctrl_alu_op_decoder #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) uAluOpDecoder (
        .state_i  (state_q),
        .opcode_i (opcode),
        .funct_i  (funct),
        .aluOp_o  (ALU_Op)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: expected per-cycle control
// words are queued as each cycle is driven and compared when the DUT is sampled.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int LIMIT = 4;

    localparam logic [3:0] OPC_R    = 4'd0;
    localparam logic [3:0] OPC_LD   = 4'd1;
    localparam logic [3:0] OPC_ST   = 4'd2;
    localparam logic [3:0] OPC_ADDI = 4'd3;
    localparam logic [3:0] OPC_BEQ  = 4'd4;
    localparam logic [3:0] OPC_BNE  = 4'd5;
    localparam logic [3:0] OPC_J    = 4'd6;
    localparam logic [3:0] OPC_HALT = 4'd7;
    localparam logic [3:0] OPC_BAD  = 4'd9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALU_Op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, illegal_op, mem_timeout, halted;
    logic [3:0] state_dbg;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aluOp;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       iOrD;
        logic       memRd;
        logic       memWr;
        logic       irWr;
        logic       regWr;
        logic       regDst;
        logic       memToReg;
        logic       illegal;
        logic       timeout;
        logic       halted;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
        outs_t mask;
    } sbItem_t;

    sbItem_t sb[$];
    int      errors = 0;
    int      checks = 0;
    logic    expTimeout = 1'b0;
    outs_t   obs;

    assign obs = {state_dbg, ALU_Op, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
                  mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  illegal_op, mem_timeout, halted};

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .OPCODE_W(4), .ALUOP_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ALU_Op      (ALU_Op),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeLimit: observed=still running required=finished");
        $fatal(1, "[TB] time limit expired");
    end

    // Expected control word for one cycle; fields the state leaves undefined are masked out.
    task automatic buildExp(input state_e s, input logic ready, output outs_t e, output outs_t m);
        e = '0;
        m = '0;
        m.st = '1; m.pcEn = 1'b1; m.memRd = 1'b1; m.memWr = 1'b1; m.irWr = 1'b1;
        m.regWr = 1'b1; m.illegal = 1'b1; m.timeout = 1'b1; m.halted = 1'b1;
        e.st      = s;
        e.timeout = expTimeout;
        e.halted  = (s == S_HALT);
        case (s)
            S_FETCH: begin
                e.memRd = 1'b1; e.irWr = ready; e.pcEn = ready;
                e.iOrD = 1'b0;  m.iOrD = 1'b1;
                e.srcA = 1'b0;  m.srcA = 1'b1;
                e.srcB = 2'b01; m.srcB = '1;
                e.aluOp = 3'd0; m.aluOp = '1;
                e.pcSrc = 2'b00; m.pcSrc = '1;
            end
            S_DECODE: begin
                e.srcA = 1'b0;  m.srcA = 1'b1;
                e.srcB = 2'b11; m.srcB = '1;
                e.aluOp = 3'd0; m.aluOp = '1;
                e.illegal = (opcode >= 4'd8);
            end
            S_MEMADR, S_ADDI_EX: begin
                e.srcA = 1'b1;  m.srcA = 1'b1;
                e.srcB = 2'b10; m.srcB = '1;
                e.aluOp = 3'd0; m.aluOp = '1;
            end
            S_MEMRD: begin
                e.memRd = 1'b1; e.iOrD = 1'b1; m.iOrD = 1'b1;
            end
            S_MEMWR: begin
                e.memWr = 1'b1; e.iOrD = 1'b1; m.iOrD = 1'b1;
            end
            S_MEMWB: begin
                e.regWr = 1'b1;
                e.memToReg = 1'b1; m.memToReg = 1'b1;
                e.regDst = 1'b0;   m.regDst = 1'b1;
            end
            S_EXEC: begin
                e.srcA = 1'b1;  m.srcA = 1'b1;
                e.srcB = 2'b00; m.srcB = '1;
                e.aluOp = funct; m.aluOp = '1;
            end
            S_ALUWB: begin
                e.regWr = 1'b1;
                e.regDst = 1'b1;   m.regDst = 1'b1;
                e.memToReg = 1'b0; m.memToReg = 1'b1;
            end
            S_ADDI_WB: begin
                e.regWr = 1'b1;
                e.regDst = 1'b0;   m.regDst = 1'b1;
                e.memToReg = 1'b0; m.memToReg = 1'b1;
            end
            S_BRANCH: begin
                e.srcA = 1'b1;   m.srcA = 1'b1;
                e.srcB = 2'b00;  m.srcB = '1;
                e.aluOp = 3'd1;  m.aluOp = '1;
                e.pcSrc = 2'b01; m.pcSrc = '1;
                e.pcEn = (opcode == OPC_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                e.pcSrc = 2'b10; m.pcSrc = '1;
                e.pcEn = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput();
        sbItem_t it;
        @(negedge clk);
        it = sb.pop_front();
        checks++;
        assert ((obs & it.mask) === (it.exp & it.mask)) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h required=%h (mask %h)", it.tag, obs & it.mask, it.exp & it.mask, it.mask);
        end
    endtask

    task automatic applyStimulus(input string tag, input state_e s, input logic ready);
        sbItem_t it;
        mem_ready = ready;
        it.tag = tag;
        buildExp(s, ready, it.exp, it.mask);
        sb.push_back(it);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d required=%0d", tag, observed, expected);
        end
    endtask

    task automatic runInstr(input string tag, input logic [3:0] op, input logic [2:0] fn,
                            input logic z, input int fetchWait, input int memWait);
        opcode = op;
        funct  = fn;
        zero   = z;
        repeat (fetchWait) applyStimulus({tag, ".fetchWait"}, S_FETCH, 1'b0);
        applyStimulus({tag, ".fetch"}, S_FETCH, 1'b1);
        applyStimulus({tag, ".decode"}, S_DECODE, 1'b0);
        case (op)
            OPC_R: begin
                applyStimulus({tag, ".exec"}, S_EXEC, 1'b0);
                applyStimulus({tag, ".aluwb"}, S_ALUWB, 1'b0);
            end
            OPC_ADDI: begin
                applyStimulus({tag, ".addiEx"}, S_ADDI_EX, 1'b0);
                applyStimulus({tag, ".addiWb"}, S_ADDI_WB, 1'b0);
            end
            OPC_LD: begin
                applyStimulus({tag, ".memadr"}, S_MEMADR, 1'b0);
                repeat (memWait) applyStimulus({tag, ".memrdWait"}, S_MEMRD, 1'b0);
                applyStimulus({tag, ".memrd"}, S_MEMRD, 1'b1);
                applyStimulus({tag, ".memwb"}, S_MEMWB, 1'b0);
            end
            OPC_ST: begin
                applyStimulus({tag, ".memadr"}, S_MEMADR, 1'b0);
                repeat (memWait) applyStimulus({tag, ".memwrWait"}, S_MEMWR, 1'b0);
                applyStimulus({tag, ".memwr"}, S_MEMWR, 1'b1);
            end
            OPC_BEQ, OPC_BNE: applyStimulus({tag, ".branch"}, S_BRANCH, 1'b0);
            OPC_J:            applyStimulus({tag, ".jump"}, S_JUMP, 1'b0);
            OPC_HALT: begin
                applyStimulus({tag, ".halt0"}, S_HALT, 1'b1);
                applyStimulus({tag, ".halt1"}, S_HALT, 1'b0);
                applyStimulus({tag, ".halt2"}, S_HALT, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic pulseReset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = OPC_R;
        funct     = 3'd0;
        zero      = 1'b0;
        #2;
        checkValue("rst.state", state_dbg, 4'(S_FETCH));
        checkValue("rst.irWrite", {3'b0, ir_write}, 4'd0);
        checkValue("rst.pcEn", {3'b0, pc_en}, 4'd0);
        checkValue("rst.memRead", {3'b0, mem_read}, 4'd0);
        checkValue("rst.flags", {2'b0, mem_timeout, halted}, 4'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runInstr("rtype1", OPC_R, 3'd1, 1'b0, 0, 0);
        runInstr("addi", OPC_ADDI, 3'd0, 1'b0, 0, 0);
        runInstr("ldWait3", OPC_LD, 3'd0, 1'b0, 0, 3);
        runInstr("stWait1", OPC_ST, 3'd0, 1'b0, 0, 1);
        runInstr("beqTaken", OPC_BEQ, 3'd0, 1'b1, 0, 0);
        runInstr("bneZero", OPC_BNE, 3'd0, 1'b1, 0, 0);
        runInstr("beqNot", OPC_BEQ, 3'd0, 1'b0, 0, 0);
        runInstr("bneTaken", OPC_BNE, 3'd0, 1'b0, 0, 0);
        runInstr("jump", OPC_J, 3'd0, 1'b0, 0, 0);
        runInstr("rtypeSlt", OPC_R, 3'd5, 1'b0, 2, 0);
        runInstr("illegal", OPC_BAD, 3'd0, 1'b0, 0, 0);
        runInstr("atLimit", OPC_R, 3'd7, 1'b0, LIMIT - 1, 0);
        runInstr("afterLimit", OPC_R, 3'd2, 1'b0, 1, 0);

        // Abort a store mid-wait with an asynchronous reset.
        opcode = OPC_ST;
        applyStimulus("midWr.fetch", S_FETCH, 1'b1);
        applyStimulus("midWr.decode", S_DECODE, 1'b0);
        applyStimulus("midWr.memadr", S_MEMADR, 1'b0);
        applyStimulus("midWr.memwrWait", S_MEMWR, 1'b0);
        checkValue("midWr.before", {3'b0, mem_write}, 4'd1);
        rst_n = 1'b0;
        #1;
        checkValue("midWr.memWrite", {3'b0, mem_write}, 4'd0);
        checkValue("midWr.memRead", {3'b0, mem_read}, 4'd0);
        checkValue("midWr.state", state_dbg, 4'(S_FETCH));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        runInstr("postRst", OPC_R, 3'd4, 1'b0, 0, 0);

        runInstr("haltOp", OPC_HALT, 3'd0, 1'b0, 0, 0);
        pulseReset();
        checkValue("haltRst.state", state_dbg, 4'(S_FETCH));

        // Watchdog: FETCH starved of mem_ready until the limit forces HALT.
        opcode = OPC_R;
        for (int i = 0; i < LIMIT; i++) begin
            applyStimulus("wdog.fetchWait", S_FETCH, 1'b0);
        end
        expTimeout = 1'b1;
        applyStimulus("wdog.halt0", S_HALT, 1'b1);
        applyStimulus("wdog.halt1", S_HALT, 1'b0);
        pulseReset();
        expTimeout = 1'b0;
        checkValue("wdogRst.flags", {2'b0, mem_timeout, halted}, 4'd0);
        runInstr("final", OPC_LD, 3'd0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
